bp_io_cmd_rr_arbiter: RTL and testbench

- Shares one BedRock IO command/response port on the unicore (load side) between two requesters: source 0 = NBF loader, source 1 = Ethernet controller.
- Round-robin arbitrates commands.
- Records the source of each issued command in an in-order tracking FIFO.
- Steers each returning response to its owner from the FIFO head instead of decoding the response address.
- Sits between the NBF/Ethernet command sources and the core's io_cmd_i/io_resp_o port.

---
 rtl/bp_io_cmd_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_bp_io_cmd_rr_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_io_cmd_rr_arbiter.sv
// Shares one BedRock IO command/response port between NBF (src 0) and Ethernet (src 1).
// Define BP_IO_ARB_FIXED_PRIO_EN to make source 0 always win instead of round-robin.
module bp_io_cmd_rr_arbiter #(
    parameter int msg_width_p       = 0,
    parameter int max_outstanding_p = 4
) (
    input  logic                                       clk_i,
    input  logic                                       reset_i,

    input  logic [msg_width_p-1:0]                     src0_cmd_i,
    input  logic                                       src0_cmd_v_i,
    output logic                                       src0_cmd_yumi_o,
    input  logic [msg_width_p-1:0]                     src1_cmd_i,
    input  logic                                       src1_cmd_v_i,
    output logic                                       src1_cmd_yumi_o,

    output logic [msg_width_p-1:0]                     src0_resp_o,
    output logic                                       src0_resp_v_o,
    input  logic                                       src0_resp_ready_and_i,
    output logic [msg_width_p-1:0]                     src1_resp_o,
    output logic                                       src1_resp_v_o,
    input  logic                                       src1_resp_ready_and_i,

    output logic [msg_width_p-1:0]                     io_cmd_o,
    output logic                                       io_cmd_v_o,
    input  logic                                       io_cmd_yumi_i,
    input  logic [msg_width_p-1:0]                     io_resp_i,
    input  logic                                       io_resp_v_i,
    output logic                                       io_resp_ready_and_o,

    output logic [$clog2(max_outstanding_p+1)-1:0]     outstanding_o,
    output logic                                       orphan_resp_o
);

    localparam int unsigned CntW = $clog2(max_outstanding_p + 1);
    localparam int unsigned PtrW = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam logic [CntW-1:0] CntFull = CntW'(max_outstanding_p);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(max_outstanding_p - 1);

    // Tracking FIFO: one source-id bit per issued command, popped in issue order.
    logic [max_outstanding_p-1:0] src_id_q, src_id_d;
    logic [PtrW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]              count_q,  count_d;
    logic                         orphan_q, orphan_d;
`ifndef BP_IO_ARB_FIXED_PRIO_EN
    logic                         last_q,   last_d;
`endif

    logic fifo_full, fifo_empty, head, sel, push, pop, orphan_evt;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + PtrW'(1);
    endfunction

    // Grant selection, command steering and response steering.
    always_comb begin
        fifo_full  = (count_q == CntFull);
        fifo_empty = (count_q == '0);
        head       = src_id_q[rd_ptr_q];

`ifdef BP_IO_ARB_FIXED_PRIO_EN
        sel = ~src0_cmd_v_i & src1_cmd_v_i;
`else
        sel = (src0_cmd_v_i & src1_cmd_v_i) ? ~last_q : src1_cmd_v_i;
`endif

        io_cmd_v_o      = (src0_cmd_v_i | src1_cmd_v_i) & ~fifo_full & ~reset_i;
        io_cmd_o        = sel ? src1_cmd_i : src0_cmd_i;
        push            = io_cmd_yumi_i & io_cmd_v_o;
        src0_cmd_yumi_o = push & ~sel;
        src1_cmd_yumi_o = push & sel;

        // An empty FIFO swallows any response so a stray one cannot wedge the core.
        io_resp_ready_and_o = fifo_empty
                            | (head ? src1_resp_ready_and_i : src0_resp_ready_and_i);
        src0_resp_o   = io_resp_i;
        src1_resp_o   = io_resp_i;
        src0_resp_v_o = io_resp_v_i & ~fifo_empty & ~head & ~reset_i;
        src1_resp_v_o = io_resp_v_i & ~fifo_empty &  head & ~reset_i;
        pop           = io_resp_v_i & io_resp_ready_and_o & ~fifo_empty;
        orphan_evt    = io_resp_v_i & fifo_empty;

        outstanding_o = count_q;
        orphan_resp_o = orphan_q;
    end

    // Next-state for FIFO, counter, sticky flag and priority pointer.
    always_comb begin
        src_id_d = src_id_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CntW'(push) - CntW'(pop);
        orphan_d = orphan_q | orphan_evt;
`ifndef BP_IO_ARB_FIXED_PRIO_EN
        last_d   = push ? sel : last_q;
`endif
        if (push) begin
            src_id_d[wr_ptr_q] = sel;
            wr_ptr_d           = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            src_id_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            orphan_q <= 1'b0;
`ifndef BP_IO_ARB_FIXED_PRIO_EN
            last_q   <= 1'b1;
`endif
        end else begin
            src_id_q <= src_id_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            orphan_q <= orphan_d;
`ifndef BP_IO_ARB_FIXED_PRIO_EN
            last_q   <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_bp_io_cmd_rr_arbiter.sv
// Bench for bp_io_cmd_rr_arbiter: queue-based model checked every cycle plus directed literal checks.
module tb_bp_io_cmd_rr_arbiter;

    localparam int W   = 16;
    localparam int MAX = 4;

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic [W-1:0]   src0_cmd_i, src1_cmd_i;
    logic           src0_cmd_v_i, src1_cmd_v_i;
    logic           src0_cmd_yumi_o, src1_cmd_yumi_o;
    logic [W-1:0]   src0_resp_o, src1_resp_o;
    logic           src0_resp_v_o, src1_resp_v_o;
    logic           src0_resp_ready_and_i, src1_resp_ready_and_i;
    logic [W-1:0]   io_cmd_o;
    logic           io_cmd_v_o, io_cmd_yumi_i;
    logic [W-1:0]   io_resp_i;
    logic           io_resp_v_i, io_resp_ready_and_o;
    logic [2:0]     outstanding_o;
    logic           orphan_resp_o;
    logic           take;

    int checks = 0;
    int errors = 0;
    int glog[$];

    // Model state
    int mq[$];
    bit m_orphan = 1'b0;
    int m_last = 1;

    always #5 clk_i = ~clk_i;

    // The core side takes a command whenever it is offered and take is set.
    assign io_cmd_yumi_i = take & io_cmd_v_o;

    bp_io_cmd_rr_arbiter #(.msg_width_p(W), .max_outstanding_p(MAX)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .src0_cmd_i(src0_cmd_i), .src0_cmd_v_i(src0_cmd_v_i), .src0_cmd_yumi_o(src0_cmd_yumi_o),
        .src1_cmd_i(src1_cmd_i), .src1_cmd_v_i(src1_cmd_v_i), .src1_cmd_yumi_o(src1_cmd_yumi_o),
        .src0_resp_o(src0_resp_o), .src0_resp_v_o(src0_resp_v_o),
        .src0_resp_ready_and_i(src0_resp_ready_and_i),
        .src1_resp_o(src1_resp_o), .src1_resp_v_o(src1_resp_v_o),
        .src1_resp_ready_and_i(src1_resp_ready_and_i),
        .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_yumi_i(io_cmd_yumi_i),
        .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_ready_and_o(io_resp_ready_and_o),
        .outstanding_o(outstanding_o), .orphan_resp_o(orphan_resp_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int pack_log();
        int r = 0;
        foreach (glog[i]) r |= glog[i] << i;
        return r;
    endfunction

    // Per-cycle compare against the model, then advance the model for the coming edge.
    always @(negedge clk_i) begin
        bit ev, push, pop, rdy, rv0, rv1;
        int sel, n;
        if (reset_i) begin
            chk("rst_cmd_v", io_cmd_v_o, 0);
            chk("rst_yumi0", src0_cmd_yumi_o, 0);
            chk("rst_yumi1", src1_cmd_yumi_o, 0);
            chk("rst_resp_v0", src0_resp_v_o, 0);
            chk("rst_resp_v1", src1_resp_v_o, 0);
            mq.delete();
            m_orphan = 1'b0;
            m_last = 1;
        end else begin
            n  = mq.size();
            ev = (src0_cmd_v_i || src1_cmd_v_i) && (n < MAX);
`ifdef BP_IO_ARB_FIXED_PRIO_EN
            sel = src0_cmd_v_i ? 0 : 1;
`else
            if (src0_cmd_v_i && src1_cmd_v_i) sel = 1 - m_last;
            else                              sel = src1_cmd_v_i ? 1 : 0;
`endif
            chk("cmd_v", io_cmd_v_o, ev);
            if (ev) chk("cmd_data", io_cmd_o, (sel == 1) ? src1_cmd_i : src0_cmd_i);
            push = take && ev;
            chk("yumi0", src0_cmd_yumi_o, push && sel == 0);
            chk("yumi1", src1_cmd_yumi_o, push && sel == 1);

            rdy = (n == 0) ? 1'b1 : ((mq[0] == 1) ? src1_resp_ready_and_i : src0_resp_ready_and_i);
            rv0 = io_resp_v_i && n > 0 && mq[0] == 0;
            rv1 = io_resp_v_i && n > 0 && mq[0] == 1;
            chk("resp_ready", io_resp_ready_and_o, rdy);
            chk("resp_v0", src0_resp_v_o, rv0);
            chk("resp_v1", src1_resp_v_o, rv1);
            if (n > 0) begin
                chk("resp_d0", src0_resp_o, io_resp_i);
                chk("resp_d1", src1_resp_o, io_resp_i);
            end
            chk("outstanding", outstanding_o, n);
            chk("orphan", orphan_resp_o, m_orphan);
            chk("no_overflow", outstanding_o <= MAX, 1);

            if (src0_cmd_yumi_o) glog.push_back(0);
            if (src1_cmd_yumi_o) glog.push_back(1);

            pop = io_resp_v_i && rdy && n > 0;
            if (io_resp_v_i && n == 0) m_orphan = 1'b1;
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(sel);
                m_last = sel;
            end
        end
    end

    initial begin
        reset_i = 1'b1;
        src0_cmd_i = '0; src1_cmd_i = '0;
        src0_cmd_v_i = 0; src1_cmd_v_i = 0; take = 0;
        io_resp_i = '0; io_resp_v_i = 0;
        src0_resp_ready_and_i = 1; src1_resp_ready_and_i = 1;

        // Reset state
        repeat (2) step();
        chk("lit_rst_outst", outstanding_o, 0);
        chk("lit_rst_orphan", orphan_resp_o, 0);
        src0_cmd_v_i = 1; #1;
        chk("lit_rst_gated_v", io_cmd_v_o, 0);
        src0_cmd_v_i = 0;
        reset_i = 0;
        step();

        // Both valid, consume every cycle until full
        glog.delete();
        src0_cmd_i = 16'hA001; src1_cmd_i = 16'hB001;
        src0_cmd_v_i = 1; src1_cmd_v_i = 1; take = 1;
        repeat (4) step();
        chk("lit_t1_cmd_v_full", io_cmd_v_o, 0);
        chk("lit_t1_outst", outstanding_o, 4);
        chk("lit_t1_ngrants", glog.size(), 4);
`ifdef BP_IO_ARB_FIXED_PRIO_EN
        chk("lit_t1_grants", pack_log(), 0);
`else
        chk("lit_t1_grants", pack_log(), 32'b1010);
`endif

        // Full: pop and new command in the same cycle; command waits one cycle
        src1_cmd_v_i = 0;
        io_resp_v_i = 1; io_resp_i = 16'hC001;
        #1;
        chk("lit_t4_blocked", io_cmd_v_o, 0);
        step();
        io_resp_v_i = 0;
        chk("lit_t4_outst3", outstanding_o, 3);
        chk("lit_t4_nogrant", glog.size(), 4);
        #1;
        chk("lit_t4_cmd_v", io_cmd_v_o, 1);
        step();
        chk("lit_t4_outst4", outstanding_o, 4);
        chk("lit_t4_grant", glog.size(), 5);
        take = 0; src0_cmd_v_i = 0;
        io_resp_v_i = 1;
        repeat (4) step();
        io_resp_v_i = 0;
        chk("lit_t4_drained", outstanding_o, 0);

        // src1 then src0, responses steered in issue order
        take = 1;
        src1_cmd_v_i = 1; src1_cmd_i = 16'hB002; step();
        src1_cmd_v_i = 0; src0_cmd_v_i = 1; src0_cmd_i = 16'hA002; step();
        src0_cmd_v_i = 0; take = 0;
        chk("lit_t2_outst2", outstanding_o, 2);
        io_resp_v_i = 1; io_resp_i = 16'hD001; #1;
        chk("lit_t2_first_v1", src1_resp_v_o, 1);
        chk("lit_t2_first_v0", src0_resp_v_o, 0);
        step();
        chk("lit_t2_outst1", outstanding_o, 1);
        chk("lit_t2_second_v0", src0_resp_v_o, 1);
        chk("lit_t2_second_v1", src1_resp_v_o, 0);
        step();
        io_resp_v_i = 0;
        chk("lit_t2_outst0", outstanding_o, 0);

        // Head src1 not ready blocks the response even though src0 is ready
        take = 1; src1_cmd_v_i = 1; step();
        src1_cmd_v_i = 0; take = 0;
        io_resp_v_i = 1; src1_resp_ready_and_i = 0; src0_resp_ready_and_i = 1; #1;
        chk("lit_t3_not_ready", io_resp_ready_and_o, 0);
        repeat (2) step();
        chk("lit_t3_held", outstanding_o, 1);
        src1_resp_ready_and_i = 1; #1;
        chk("lit_t3_ready", io_resp_ready_and_o, 1);
        step();
        io_resp_v_i = 0;
        chk("lit_t3_popped", outstanding_o, 0);

        // Orphan response, sticky until reset; reset discards in-flight commands
        io_resp_v_i = 1; io_resp_i = 16'hE001; #1;
        chk("lit_t5_ready", io_resp_ready_and_o, 1);
        chk("lit_t5_v0", src0_resp_v_o, 0);
        chk("lit_t5_v1", src1_resp_v_o, 0);
        step();
        io_resp_v_i = 0;
        chk("lit_t5_orphan", orphan_resp_o, 1);
        repeat (3) step();
        chk("lit_t5_sticky", orphan_resp_o, 1);
        take = 1; src0_cmd_v_i = 1; repeat (2) step();
        take = 0; src0_cmd_v_i = 0;
        chk("lit_t5_outst2", outstanding_o, 2);
        reset_i = 1; step();
        chk("lit_t5_rst_outst", outstanding_o, 0);
        chk("lit_t5_rst_orphan", orphan_resp_o, 0);
        reset_i = 0; step();

`ifdef BP_IO_ARB_FIXED_PRIO_EN
        // Source 0 always wins; source 1 only after source 0 drops
        glog.delete();
        src0_cmd_v_i = 1; src1_cmd_v_i = 1; take = 1;
        repeat (3) step();
        chk("lit_fp_n3", glog.size(), 3);
        chk("lit_fp_grants", pack_log(), 0);
        src0_cmd_v_i = 0; step();
        chk("lit_fp_n4", glog.size(), 4);
        chk("lit_fp_src1", glog[3], 1);
        src1_cmd_v_i = 0; take = 0;
        io_resp_v_i = 1;
        repeat (4) step();
        io_resp_v_i = 0;
`endif

        // Mixed traffic with backpressure, checked by the model every cycle
        for (int i = 0; i < 300; i++) begin
            src0_cmd_v_i = 1'($urandom_range(0, 1));
            src1_cmd_v_i = 1'($urandom_range(0, 1));
            src0_cmd_i = W'($urandom);
            src1_cmd_i = W'($urandom);
            take = ($urandom_range(0, 3) != 0);
            io_resp_v_i = ($urandom_range(0, 2) != 0);
            io_resp_i = W'($urandom);
            src0_resp_ready_and_i = ($urandom_range(0, 3) != 0);
            src1_resp_ready_and_i = ($urandom_range(0, 3) != 0);
            step();
        end
        src0_cmd_v_i = 0; src1_cmd_v_i = 0; take = 0; io_resp_v_i = 0;
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
